// File: rtl/br_redirect_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// br_redirect_ctrl_pkg
// Shared definitions for the branch redirect controller:
//   XLEN          datapath width
//   NPC_*         npc_sel decision codes from the branch unit
//   state_t       redirect FSM state encoding
//   calc_target   redirect target for a taken branch (mod 2^XLEN)
// ----------------------------------------------------------------------------
package br_redirect_ctrl_pkg;

   localparam int XLEN = 32;

   localparam logic [1:0] NPC_SEQ  = 2'b00;
   localparam logic [1:0] NPC_ILL  = 2'b01;
   localparam logic [1:0] NPC_JIRL = 2'b10;
   localparam logic [1:0] NPC_REL  = 2'b11;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   // jirl is register-relative, everything else taken is pc-relative.
   // The carry out of the add is dropped on purpose (address wrap).
   function automatic logic [XLEN-1:0] calc_target(
      input logic [1:0]      sel,
      input logic [XLEN-1:0] pc,
      input logic [XLEN-1:0] rj,
      input logic [XLEN-1:0] offs
   );
      logic [XLEN-1:0] base;
      base = (sel == NPC_JIRL) ? rj : pc;
      return base + offs;
   endfunction

endpackage

// File: rtl/br_perf_cnt.sv
// ----------------------------------------------------------------------------
// br_perf_cnt
// Branch performance counters, both wrapping at 2^XLEN.
//   clk, rst      clock, async active-high reset
//   inc_br        a branch was resolved this cycle
//   inc_taken     a redirect was issued this cycle
//   br_cnt        resolved branch count
//   taken_cnt     issued redirect count
// ----------------------------------------------------------------------------
module br_perf_cnt
   import br_redirect_ctrl_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            inc_br,
   input  logic            inc_taken,
   output logic [XLEN-1:0] br_cnt,
   output logic [XLEN-1:0] taken_cnt
);

   logic [XLEN-1:0] br_q;
   logic [XLEN-1:0] taken_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         br_q    <= '0;
         taken_q <= '0;
      end else begin
         if (inc_br)    br_q    <= br_q + 1'b1;
         if (inc_taken) taken_q <= taken_q + 1'b1;
      end
   end

   assign br_cnt    = br_q;
   assign taken_cnt = taken_q;

endmodule

// File: rtl/br_redirect_ctrl.sv
// ----------------------------------------------------------------------------
// br_redirect_ctrl
// Turns a resolved branch in EX into a fetch redirect and holds it until the
// fetch unit accepts it.
//   clk, rst            clock, async active-high reset
//   ex_valid, ex_is_br  EX holds a valid branch-class instruction
//   npc_sel             branch decision (00 seq, 01 illegal, 10 jirl, 11 rel)
//   ex_pc, ex_offs      EX pc and pre-shifted sign-extended offset
//   ex_rj               jirl base register value
//   fetch_ready         fetch accepts the pending redirect
//   redir_valid/pc      pending redirect request and its target
//   adef                target not word aligned (valid with redir_valid)
//   flush_if/flush_id   kill IF/ID register contents at next edge
//   stall_ex            freeze EX and earlier while a redirect is pending
//   illegal_sel         sticky: a branch arrived with npc_sel=01
//   br_cnt/taken_cnt    performance counters
// ----------------------------------------------------------------------------
module br_redirect_ctrl
   import br_redirect_ctrl_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            ex_valid,
   input  logic            ex_is_br,
   input  logic [1:0]      npc_sel,
   input  logic [XLEN-1:0] ex_pc,
   input  logic [XLEN-1:0] ex_offs,
   input  logic [XLEN-1:0] ex_rj,
   input  logic            fetch_ready,
   output logic            redir_valid,
   output logic [XLEN-1:0] redir_pc,
   output logic            flush_if,
   output logic            flush_id,
   output logic            stall_ex,
   output logic            adef,
   output logic            illegal_sel,
   output logic [XLEN-1:0] br_cnt,
   output logic [XLEN-1:0] taken_cnt
);

   state_t          state;
   logic            idle;
   logic            br_in_ex;
   logic            taken_evt;
   logic [XLEN-1:0] target;

   assign idle      = (state == ST_IDLE);
   // EX contents are only looked at in IDLE; during HOLD EX is frozen and
   // whatever sits there is re-presented after the handshake.
   assign br_in_ex  = idle & ex_valid & ex_is_br;
   assign taken_evt = br_in_ex & ((npc_sel == NPC_JIRL) | (npc_sel == NPC_REL));
   assign target    = calc_target(npc_sel, ex_pc, ex_rj, ex_offs);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         redir_valid <= 1'b0;
         redir_pc    <= '0;
         adef        <= 1'b0;
         illegal_sel <= 1'b0;
      end else begin
         if (br_in_ex && npc_sel == NPC_ILL) illegal_sel <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (taken_evt) begin
                  state       <= ST_HOLD;
                  redir_valid <= 1'b1;
                  redir_pc    <= target;
                  adef        <= |target[1:0];
               end
            end
            ST_HOLD: begin
               if (fetch_ready) begin
                  state       <= ST_IDLE;
                  redir_valid <= 1'b0;
               end
            end
            default: begin
               state       <= ST_IDLE;
               redir_valid <= 1'b0;
            end
         endcase
      end
   end

   // Flushes/stall are combinational so the wrong-path fetch is killed in the
   // same cycle the branch resolves; all forced low while in reset.
   assign flush_if = ~rst & (taken_evt | ~idle);
   assign flush_id = ~rst & taken_evt;
   assign stall_ex = ~rst & ~idle;

   br_perf_cnt u_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc_br    (br_in_ex),
      .inc_taken (taken_evt),
      .br_cnt    (br_cnt),
      .taken_cnt (taken_cnt)
   );

endmodule

// File: tb/tb_br_redirect_ctrl.sv
module tb_br_redirect_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ex_valid = 1'b0;
   logic        ex_is_br = 1'b0;
   logic [1:0]  npc_sel = 2'b00;
   logic [31:0] ex_pc = '0;
   logic [31:0] ex_offs = '0;
   logic [31:0] ex_rj = '0;
   logic        fetch_ready = 1'b0;
   logic        redir_valid;
   logic [31:0] redir_pc;
   logic        flush_if, flush_id, stall_ex, adef, illegal_sel;
   logic [31:0] br_cnt, taken_cnt;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   br_redirect_ctrl dut (
      .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_is_br(ex_is_br),
      .npc_sel(npc_sel), .ex_pc(ex_pc), .ex_offs(ex_offs), .ex_rj(ex_rj),
      .fetch_ready(fetch_ready), .redir_valid(redir_valid), .redir_pc(redir_pc),
      .flush_if(flush_if), .flush_id(flush_id), .stall_ex(stall_ex), .adef(adef),
      .illegal_sel(illegal_sel), .br_cnt(br_cnt), .taken_cnt(taken_cnt)
   );

   // ---------------- behavioural model ----------------
   bit          m_pending;   // a redirect is outstanding
   logic [31:0] m_pc;
   bit          m_adef;
   bit          m_ill;
   logic [31:0] m_br, m_taken;

   function automatic bit is_taken_now();
      return !m_pending && ex_valid && ex_is_br && (npc_sel == 2'd2 || npc_sel == 2'd3);
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_pending = 0; m_pc = 0; m_adef = 0; m_ill = 0; m_br = 0; m_taken = 0;
      end else if (m_pending) begin
         if (fetch_ready) m_pending = 0;
      end else if (ex_valid && ex_is_br) begin
         m_br = m_br + 1;
         if (npc_sel == 2'd1) m_ill = 1;
         if (npc_sel == 2'd2 || npc_sel == 2'd3) begin
            m_pc      = ((npc_sel == 2'd3) ? ex_pc : ex_rj) + ex_offs;
            m_adef    = (m_pc % 4) != 0;
            m_taken   = m_taken + 1;
            m_pending = 1;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // per-cycle comparison against the model
   always @(negedge clk) begin
      if (cmp_en) begin
         bit tk;
         tk = !rst && is_taken_now();
         chk("m.redir_valid", {31'd0, redir_valid}, {31'd0, m_pending});
         chk("m.flush_if", {31'd0, flush_if}, {31'd0, !rst && (m_pending || tk)});
         chk("m.flush_id", {31'd0, flush_id}, {31'd0, tk});
         chk("m.stall_ex", {31'd0, stall_ex}, {31'd0, !rst && m_pending});
         chk("m.illegal_sel", {31'd0, illegal_sel}, {31'd0, m_ill});
         chk("m.br_cnt", br_cnt, m_br);
         chk("m.taken_cnt", taken_cnt, m_taken);
         if (m_pending) begin
            chk("m.redir_pc", redir_pc, m_pc);
            chk("m.adef", {31'd0, adef}, {31'd0, m_adef});
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit v, input logic [1:0] sel, input logic [31:0] pc,
                        input logic [31:0] offs, input logic [31:0] rj, input bit fr);
      ex_valid = v; ex_is_br = v; npc_sel = sel;
      ex_pc = pc; ex_offs = offs; ex_rj = rj; fetch_ready = fr;
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      #1;
      rst = 1'b0;
   endtask

   logic [31:0] br_snap;

   initial begin
      step(); step();
      chk("rst.redir_valid", {31'd0, redir_valid}, 32'd0);
      chk("rst.redir_pc", redir_pc, 32'd0);
      chk("rst.br_cnt", br_cnt, 32'd0);
      chk("rst.flush_if", {31'd0, flush_if}, 32'd0);
      rst = 1'b0;
      cmp_en = 1'b1;

      // reset mid-HOLD, then first event right after reset
      drive(1, 2'd3, 32'h0000_1000, 32'h4, 0, 0);
      step();
      chk("hold.redir_valid", {31'd0, redir_valid}, 32'd1);
      rst = 1'b1;
      #1;
      chk("midrst.redir_valid", {31'd0, redir_valid}, 32'd0);
      chk("midrst.stall_ex", {31'd0, stall_ex}, 32'd0);
      chk("midrst.br_cnt", br_cnt, 32'd0);
      chk("midrst.taken_cnt", taken_cnt, 32'd0);
      rst = 1'b0;
      drive(1, 2'd3, 32'h1C00_0000, 32'h10, 0, 1);
      #1;
      chk("a.flush_if", {31'd0, flush_if}, 32'd1);
      chk("a.flush_id", {31'd0, flush_id}, 32'd1);
      step();
      chk("a.redir_valid", {31'd0, redir_valid}, 32'd1);
      chk("a.redir_pc", redir_pc, 32'h1C00_0010);
      chk("a.taken_cnt", taken_cnt, 32'd1);
      chk("a.br_cnt", br_cnt, 32'd1);
      drive(0, 2'd0, 0, 0, 0, 1);
      step();
      chk("a.idle", {31'd0, redir_valid}, 32'd0);

      // jirl with 3 cycles of backpressure
      drive(1, 2'd2, 32'h0, 32'hFFFF_FFFC, 32'h1C00_0100, 0);
      step();
      drive(0, 2'd0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         if (i == 3) fetch_ready = 1'b1;
         chk("b.redir_pc", redir_pc, 32'h1C00_00FC);
         chk("b.stall_ex", {31'd0, stall_ex}, 32'd1);
         chk("b.flush_if", {31'd0, flush_if}, 32'd1);
         chk("b.flush_id", {31'd0, flush_id}, 32'd0);
         step();
      end
      chk("b.idle", {31'd0, redir_valid}, 32'd0);
      chk("b.stall_off", {31'd0, stall_ex}, 32'd0);

      // not-taken then illegal
      pulse_rst();
      drive(1, 2'd0, 32'h2000, 32'h40, 0, 0);
      step();
      chk("c.seq_novalid", {31'd0, redir_valid}, 32'd0);
      npc_sel = 2'd1;
      step();
      drive(0, 2'd0, 0, 0, 0, 0);
      chk("c.ill_novalid", {31'd0, redir_valid}, 32'd0);
      chk("c.br_cnt", br_cnt, 32'd2);
      chk("c.taken_cnt", taken_cnt, 32'd0);
      chk("c.illegal", {31'd0, illegal_sel}, 32'd1);
      step(); step();
      chk("c.illegal_sticky", {31'd0, illegal_sel}, 32'd1);

      // wrap and misalignment, with br_cnt at its maximum
      dut.u_cnt.br_q = 32'hFFFF_FFFF;
      m_br = 32'hFFFF_FFFF;
      drive(1, 2'd3, 32'hFFFF_FFF0, 32'h12, 0, 1);
      step();
      drive(0, 2'd0, 0, 0, 0, 1);
      chk("d.redir_pc", redir_pc, 32'h0000_0002);
      chk("d.adef", {31'd0, adef}, 32'd1);
      chk("d.br_wrap", br_cnt, 32'd0);
      step();

      // branch in EX during HOLD is ignored
      drive(1, 2'd3, 32'h100, 32'h8, 0, 0);
      step();
      br_snap = br_cnt;
      drive(1, 2'd3, 32'h200, 32'h8, 0, 0);
      step(); step();
      chk("e.hold_pc", redir_pc, 32'h108);
      chk("e.hold_br", br_cnt, br_snap);
      drive(0, 2'd0, 0, 0, 0, 1);
      step();

      // back-to-back: taken at N and N+2
      drive(1, 2'd3, 32'h300, 32'h20, 0, 1);
      step();
      drive(0, 2'd0, 0, 0, 0, 1);
      chk("f.first_pc", redir_pc, 32'h320);
      step();
      drive(1, 2'd2, 0, 32'h4, 32'h400, 1);
      #1;
      chk("f.gap_idle", {31'd0, redir_valid}, 32'd0);
      chk("f.second_flush_id", {31'd0, flush_id}, 32'd1);
      step();
      drive(0, 2'd0, 0, 0, 0, 1);
      chk("f.second_pc", redir_pc, 32'h404);
      chk("f.second_valid", {31'd0, redir_valid}, 32'd1);
      step(); step();

      cmp_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
